// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
//
// Shared definitions for the Galois LFSR random-number generator family.
//
// Contents:
//   lfsr_state_e   - word-assembly FSM states (FILL: stepping and shifting bits
//                    into the word register; HOLD: a finished word is offered
//                    to the consumer and the LFSR is frozen).
//   PRIM_TAPS_*    - known-primitive Galois tap masks for common widths. With
//                    one of these masks and a nonzero seed the state walks all
//                    2^WIDTH-1 nonzero values before repeating.
//   prim_taps()    - width -> primitive mask lookup (returns 0 for widths that
//                    have no entry, so callers must supply their own mask).
// -----------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } lfsr_state_e;

    // Bit i set means the feedback bit is XORed into state bit i after the
    // left shift. Bit 0 set is what keeps these masks primitive.
    localparam logic [3:0]  PRIM_TAPS_4  = 4'h3;
    localparam logic [7:0]  PRIM_TAPS_8  = 8'h1D;
    localparam logic [15:0] PRIM_TAPS_16 = 16'h002D;
    localparam logic [31:0] PRIM_TAPS_32 = 32'h000000C5;

    function automatic logic [31:0] prim_taps(input int unsigned width);
        logic [31:0] mask;
        mask = '0;
        case (width)
            4:       mask = {28'h0, PRIM_TAPS_4};
            8:       mask = {24'h0, PRIM_TAPS_8};
            16:      mask = {16'h0, PRIM_TAPS_16};
            32:      mask = PRIM_TAPS_32;
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// -----------------------------------------------------------------------------
// lfsr_step
//
// One step of a shift-left Galois LFSR, purely combinational.
//
//   feedback   = state[WIDTH-1]
//   next_state = {state[WIDTH-2:0], 1'b0} ^ (feedback ? taps : 0)
//
// The feedback bit is also the bit the generator emits for this step.
//
// Ports:
//   state_i  in  WIDTH  current LFSR state
//   taps_i   in  WIDTH  tap mask (bit i set = feedback XORed into bit i)
//   state_o  out WIDTH  state after one step
//   fb_o     out 1      feedback / emitted bit
//
// WIDTH must be at least 3; narrower registers do not make a useful LFSR.
// -----------------------------------------------------------------------------
module lfsr_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] state_i,
    input  logic [WIDTH-1:0] taps_i,
    output logic [WIDTH-1:0] state_o,
    output logic             fb_o
);

    logic             fb;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] fb_mask;

    always_comb begin
        fb      = state_i[WIDTH-1];
        shifted = {state_i[WIDTH-2:0], 1'b0};
        // Replicate the feedback bit so the XOR is a plain AND-mask.
        fb_mask = {WIDTH{fb}} & taps_i;
        state_o = shifted ^ fb_mask;
        fb_o    = fb;
    end

endmodule

// File: rtl/lfsr_rng_gen.sv
// -----------------------------------------------------------------------------
// lfsr_rng_gen
//
// Parametrised Galois LFSR random-number generator. Each enabled FILL cycle
// advances the LFSR by one step and shifts the emitted bit into a word
// register; after OUT_W bits the word is presented on rand_word and the
// generator waits in HOLD for the consumer. Tap mask and seed can be reloaded
// at run time. An all-zero state (which would otherwise lock the LFSR forever)
// is detected and replaced by DEFAULT_SEED, and the sticky lockup flag is set.
//
// Handshake: a word is transferred on every rising edge where rand_valid and
// rand_ready are both high. rand_valid is raised only with a complete word,
// rand_word is stable for as long as rand_valid is high, and rand_valid drops
// only after a transfer, on start, or on load (which discards the word).
// rand_ready may be high or low at any time and has no effect outside HOLD.
//
// Ports:
//   clk         in   1      clock, rising edge
//   start       in   1      synchronous active-high reset (highest priority)
//   en          in   1      step enable for FILL; low freezes state/word/count
//   load        in   1      strobe: capture seed_in and taps_in, restart word
//   seed_in     in   WIDTH  seed captured on load (zero is replaced)
//   taps_in     in   WIDTH  tap mask captured on load (not checked)
//   rand_word   out  OUT_W  assembled word; first emitted bit is the MSB
//   rand_valid  out  1      word available
//   rand_ready  in   1      consumer accepts the word
//   lockup      out  1      sticky: an all-zero state was seen and replaced
//   state       out  WIDTH  current LFSR state
//   fsm_state   out  1      FILL/HOLD, for observation
//
// Throughput with rand_ready held high and en high: one word per OUT_W+1
// cycles (OUT_W stepping cycles plus the HOLD transfer cycle).
// -----------------------------------------------------------------------------
module lfsr_rng_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               OUT_W        = 8,
    parameter logic [WIDTH-1:0] DEFAULT_TAPS = PRIM_TAPS_16,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'h0001
) (
    input  logic              clk,
    input  logic              start,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  seed_in,
    input  logic [WIDTH-1:0]  taps_in,
    output logic [OUT_W-1:0]  rand_word,
    output logic              rand_valid,
    input  logic              rand_ready,
    output logic              lockup,
    output logic [WIDTH-1:0]  state,
    output lfsr_state_e       fsm_state
);

    // Bit counter only needs to reach OUT_W-1; keep at least one bit.
    localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OUT_W - 1);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] state_q,  state_d;
    logic [WIDTH-1:0] taps_q,   taps_d;
    logic [OUT_W-1:0] shreg_q,  shreg_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [OUT_W-1:0] rand_q,   rand_d;
    logic             valid_q,  valid_d;
    logic             lockup_q, lockup_d;
    lfsr_state_e      fsm_q,    fsm_d;

    // -------------------------------------------------------------------------
    // Step function
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] step_state;
    logic             step_fb;

    lfsr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .state_i (state_q),
        .taps_i  (taps_q),
        .state_o (step_state),
        .fb_o    (step_fb)
    );

    // Shift the new bit in at the LSB; the oldest bit ends up in the MSB.
    // Building OUT_W+1 bits and dropping the top one works for OUT_W=1 too.
    logic [OUT_W:0]   shreg_wide;
    logic [OUT_W-1:0] shreg_next;

    always_comb begin
        shreg_wide = {shreg_q, step_fb};
        shreg_next = shreg_wide[OUT_W-1:0];
    end

    logic state_is_zero;
    logic seed_is_zero;

    always_comb begin
        state_is_zero = (state_q == '0);
        seed_is_zero  = (seed_in == '0);
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        taps_d   = taps_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        rand_d   = rand_q;
        valid_d  = valid_q;
        lockup_d = lockup_q;
        fsm_d    = fsm_q;

        if (load) begin
            // Load wins over any handshake in the same cycle: a held word is
            // dropped and word assembly restarts. No step on this cycle.
            taps_d   = taps_in;
            shreg_d  = '0;
            bitcnt_d = '0;
            valid_d  = 1'b0;
            fsm_d    = ST_FILL;
            if (seed_is_zero) begin
                state_d  = DEFAULT_SEED;
                lockup_d = 1'b1;
            end else begin
                state_d  = seed_in;
            end
        end else begin
            case (fsm_q)
                ST_FILL: begin
                    if (state_is_zero) begin
                        // A runtime tap mask can drive the state to zero,
                        // where it would stick. Reseed; this cycle emits no
                        // bit and leaves the partial word untouched.
                        state_d  = DEFAULT_SEED;
                        lockup_d = 1'b1;
                    end else if (en) begin
                        state_d = step_state;
                        if (bitcnt_q == LAST_BIT) begin
                            rand_d   = shreg_next;
                            valid_d  = 1'b1;
                            shreg_d  = '0;
                            bitcnt_d = '0;
                            fsm_d    = ST_HOLD;
                        end else begin
                            shreg_d  = shreg_next;
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // LFSR frozen; word stays put until the consumer takes it.
                    // en does not gate the transfer.
                    if (valid_q && rand_ready) begin
                        valid_d = 1'b0;
                        fsm_d   = ST_FILL;
                    end
                end
                default: begin
                    fsm_d   = ST_FILL;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (start) begin
            state_q  <= DEFAULT_SEED;
            taps_q   <= DEFAULT_TAPS;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            rand_q   <= '0;
            valid_q  <= 1'b0;
            lockup_q <= 1'b0;
            fsm_q    <= ST_FILL;
        end else begin
            state_q  <= state_d;
            taps_q   <= taps_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            rand_q   <= rand_d;
            valid_q  <= valid_d;
            lockup_q <= lockup_d;
            fsm_q    <= fsm_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        rand_word  = rand_q;
        rand_valid = valid_q;
        lockup     = lockup_q;
        state      = state_q;
        fsm_state  = fsm_q;
    end

endmodule

// File: tb/tb_lfsr_rng_gen.sv
module tb_lfsr_rng_gen;
    import lfsr_pkg::*;

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // 4-bit DUT (main scenarios)
    // ------------------------------------------------------------------
    logic        start = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [3:0]  seed_in = 4'h0;
    logic [3:0]  taps_in = 4'h0;
    logic [3:0]  rand_word;
    logic        rand_valid;
    logic        rand_ready = 1'b0;
    logic        lockup;
    logic [3:0]  state;
    lfsr_state_e fsm_state;

    lfsr_rng_gen #(
        .WIDTH        (4),
        .OUT_W        (4),
        .DEFAULT_TAPS (4'h3),
        .DEFAULT_SEED (4'h1)
    ) dut (
        .clk        (clk),
        .start      (start),
        .en         (en),
        .load       (load),
        .seed_in    (seed_in),
        .taps_in    (taps_in),
        .rand_word  (rand_word),
        .rand_valid (rand_valid),
        .rand_ready (rand_ready),
        .lockup     (lockup),
        .state      (state),
        .fsm_state  (fsm_state)
    );

    // ------------------------------------------------------------------
    // 16-bit DUT (full-period run, in parallel)
    // ------------------------------------------------------------------
    logic        b_start = 1'b1;
    logic [15:0] b_rand_word;
    logic        b_rand_valid;
    logic        b_lockup;
    logic [15:0] b_state;
    lfsr_state_e b_fsm_state;

    lfsr_rng_gen #(
        .WIDTH        (16),
        .OUT_W        (16),
        .DEFAULT_TAPS (16'h002D),
        .DEFAULT_SEED (16'h0001)
    ) dut16 (
        .clk        (clk),
        .start      (b_start),
        .en         (1'b1),
        .load       (1'b0),
        .seed_in    (16'h0000),
        .taps_in    (16'h0000),
        .rand_word  (b_rand_word),
        .rand_valid (b_rand_valid),
        .rand_ready (1'b1),
        .lockup     (b_lockup),
        .state      (b_state),
        .fsm_state  (b_fsm_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters and check helper
    // ------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;
    logic toggle_en = 1'b0;
    logic big_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: optional en toggle before the edge, sample 1 time unit after.
    task automatic tick();
        if (toggle_en) en = ~en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        toggle_en = 1'b0;
        start = 1'b1;
        load = 1'b0;
        en = 1'b1;
        tick();
        tick();
        start = 1'b0;
    endtask

    // Ticks at least once, then until rand_valid or the budget runs out.
    task automatic wait_valid(input int max_cyc, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!rand_valid && lat < max_cyc);
    endtask

    // ------------------------------------------------------------------
    // Vector table: expected word stream and latency between words
    // ------------------------------------------------------------------
    typedef struct {
        string      name;
        logic       toggle;   // en toggled every cycle
        logic [3:0] word;
        int         lat;      // cycles from previous valid (or start drop)
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        int steps;
        logic saw_zero;
        logic [3:0] prev;
        logic hold_ok;

        vecs[0] = '{"w0_full",   1'b0, 4'h1, 4};
        vecs[1] = '{"w1_full",   1'b0, 4'h3, 5};
        vecs[2] = '{"w2_full",   1'b0, 4'h5, 5};
        vecs[3] = '{"w3_full",   1'b0, 4'hE, 5};
        vecs[4] = '{"w0_toggle", 1'b1, 4'h1, 8};
        vecs[5] = '{"w1_toggle", 1'b1, 4'h3, 8};
        vecs[6] = '{"w2_toggle", 1'b1, 4'h5, 8};
        vecs[7] = '{"w3_toggle", 1'b1, 4'hE, 8};

        // ---- reset values ----
        rand_ready = 1'b1;
        do_reset();
        check("rst_state",  {28'h0, state}, 32'h1);
        check("rst_valid",  {31'h0, rand_valid}, 32'h0);
        check("rst_lockup", {31'h0, lockup}, 32'h0);
        check("rst_rand",   {28'h0, rand_word}, 32'h0);
        check("rst_fsm",    {31'h0, fsm_state}, {31'h0, ST_FILL});

        // ---- word streams: en held high, then en toggled ----
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || i == 4) begin
                rand_ready = 1'b1;
                do_reset();
                en = 1'b1;
                toggle_en = vecs[i].toggle;
            end
            wait_valid(20, lat);
            check({vecs[i].name, "_valid"}, {31'h0, rand_valid}, 32'h1);
            check({vecs[i].name, "_word"}, {28'h0, rand_word}, {28'h0, vecs[i].word});
            check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
        end
        toggle_en = 1'b0;
        en = 1'b1;

        // ---- state period of the 4-bit LFSR ----
        do_reset();
        steps = 0;
        saw_zero = 1'b0;
        for (int c = 0; c < 40; c++) begin
            prev = state;
            tick();
            if (state != prev) steps++;
            if (state == 4'h0) saw_zero = 1'b1;
            if (state == 4'h1) break;
        end
        check("period4", steps, 15);
        check("period4_nonzero", {31'h0, saw_zero}, 32'h0);

        // ---- back-pressure: word and state frozen while ready low ----
        rand_ready = 1'b0;
        do_reset();
        wait_valid(20, lat);
        check("bp_first_lat", lat, 4);
        check("bp_first_word", {28'h0, rand_word}, 32'h1);
        for (int c = 0; c < 10; c++) begin
            tick();
            hold_ok = rand_valid && (rand_word == 4'h1) && (state == 4'h3) && (fsm_state == ST_HOLD);
            check("bp_hold", {31'h0, hold_ok}, 32'h1);
        end
        rand_ready = 1'b1;
        tick();
        check("bp_accept_valid", {31'h0, rand_valid}, 32'h0);
        wait_valid(20, lat);
        check("bp_next_lat", lat, 4);
        check("bp_next_word", {28'h0, rand_word}, 32'h3);

        // ---- zero seed on load ----
        rand_ready = 1'b0;
        do_reset();
        load = 1'b1;
        seed_in = 4'h0;
        taps_in = 4'h3;
        tick();
        load = 1'b0;
        check("zseed_state",  {28'h0, state}, 32'h1);
        check("zseed_lockup", {31'h0, lockup}, 32'h1);
        check("zseed_valid",  {31'h0, rand_valid}, 32'h0);
        for (int c = 0; c < 6; c++) tick();
        check("zseed_sticky", {31'h0, lockup}, 32'h1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zseed_clear", {31'h0, lockup}, 32'h0);

        // ---- state reaches zero through a non-primitive mask ----
        do_reset();
        load = 1'b1;
        seed_in = 4'h8;
        taps_in = 4'h0;
        tick();
        load = 1'b0;
        check("zrun_load_state", {28'h0, state}, 32'h8);
        tick();
        check("zrun_zero_state", {28'h0, state}, 32'h0);
        check("zrun_pre_lockup", {31'h0, lockup}, 32'h0);
        tick();
        check("zrun_recover_state", {28'h0, state}, 32'h1);
        check("zrun_recover_lockup", {31'h0, lockup}, 32'h1);
        // One bit (1) before recovery, then 0,0,0 from 1->2->4->8.
        wait_valid(20, lat);
        check("zrun_word_lat", lat, 3);
        check("zrun_word", {28'h0, rand_word}, 32'h8);

        // ---- load while a word is held, ready high in the same cycle ----
        rand_ready = 1'b0;
        do_reset();
        wait_valid(20, lat);
        check("ld_hold_word", {28'h0, rand_word}, 32'h1);
        load = 1'b1;
        seed_in = 4'h8;
        taps_in = 4'h3;
        rand_ready = 1'b1;
        tick();
        load = 1'b0;
        check("ld_drop_valid", {31'h0, rand_valid}, 32'h0);
        check("ld_state", {28'h0, state}, 32'h8);
        check("ld_fsm", {31'h0, fsm_state}, {31'h0, ST_FILL});
        wait_valid(20, lat);
        check("ld_new_lat", lat, 4);
        check("ld_new_word", {28'h0, rand_word}, 32'h9);

        // ---- 16-bit full period ----
        wait (big_done);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Full 16-bit period: count state changes until the seed comes back.
    initial begin
        int steps16;
        int cyc;
        logic zero16;
        logic [15:0] prev16;
        steps16 = 0;
        zero16 = 1'b0;
        b_start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        b_start = 1'b0;
        for (cyc = 0; cyc < 80000; cyc++) begin
            prev16 = b_state;
            @(posedge clk);
            #1;
            if (b_state != prev16) steps16++;
            if (b_state == 16'h0) zero16 = 1'b1;
            if (b_state == 16'h0001) break;
        end
        check("period16", steps16, 65535);
        check("period16_nonzero", {31'h0, zero16}, 32'h0);
        big_done = 1'b1;
    end

endmodule
